// File: rtl/fsm_c.sv
// Mealy detector for the serial pattern 1101 with overlap; y_out is combinational
// from the current state and x_in, gated by the synchronous active-low Reset.
module fsm_c (
  input  logic CLK,
  input  logic Reset,
  input  logic x_in,
  output logic y_out
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t state_q;
  state_t state_d;

  // State register; Reset is synchronous, so it only acts on a rising edge.
  always_ff @(posedge CLK) begin
    state_q <= state_d;
  end

  // Next-state and Mealy output; Reset low overrides any transition or match.
  always_comb begin
    state_d = S0;
    y_out   = 1'b0;
    if (!Reset) begin
      state_d = S0;
      y_out   = 1'b0;
    end else begin
      case (state_q)
        S0: state_d = x_in ? S1 : S0;
        S1: state_d = x_in ? S2 : S0;
        S2: state_d = x_in ? S2 : S3;
        S3: begin
          // A match's trailing 1 is kept as the prefix of the next pattern.
          state_d = x_in ? S1 : S0;
          y_out   = x_in;
        end
        default: state_d = S0;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_c.sv
// Directed bench for fsm_c: inputs change just after a rising edge, y_out is
// checked on the following falling edge against hand-computed values.
module tb_fsm_c;

  logic CLK;
  logic Reset;
  logic x_in;
  logic y_out;

  int n_checks = 0;
  int n_err    = 0;

  fsm_c dut (
    .CLK   (CLK),
    .Reset (Reset),
    .x_in  (x_in),
    .y_out (y_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply one input cycle, check y_out mid-cycle, then advance past the rising edge.
  task automatic step(input string tag, input logic rst, input logic x, input logic exp_y);
    Reset = rst;
    x_in  = x;
    @(negedge CLK);
    check(tag, {1'b0, y_out}, {1'b0, exp_y});
    @(posedge CLK);
    #1;
  endtask

  task automatic run_seq(input string tag, input logic [15:0] xs, input logic [15:0] ys, input int n);
    for (int i = 0; i < n; i++) begin
      step($sformatf("%s[%0d]", tag, i), 1'b1, xs[n-1-i], ys[n-1-i]);
    end
  endtask

  initial begin
    Reset = 1'b0;
    x_in  = 1'b1;

    // Reset check: two cycles with x_in=1
    step("rst0", 1'b0, 1'b1, 1'b0);
    step("rst1", 1'b0, 1'b1, 1'b0);
    check("rst_state", dut.state_q, 2'b00);

    // Basic match
    run_seq("basic", 16'b1101, 16'b0001, 4);
    check("basic_state", dut.state_q, 2'b01);

    // Overlap
    step("rst_a", 1'b0, 1'b0, 1'b0);
    run_seq("overlap", 16'b1101101, 16'b0001001, 7);

    // Long run of ones and near misses
    step("rst_b", 1'b0, 1'b0, 1'b0);
    run_seq("ones", 16'b1110100101, 16'b0000100000, 10);
    check("ones_state", dut.state_q, 2'b01);

    // Reset mid-sequence: reset while in S3 with x_in=1 must not match
    step("rst_c", 1'b0, 1'b0, 1'b0);
    run_seq("mid_pre", 16'b110, 16'b000, 3);
    check("mid_s3", dut.state_q, 2'b11);
    step("mid_rst", 1'b0, 1'b1, 1'b0);
    check("mid_after_rst", dut.state_q, 2'b00);
    run_seq("mid_post", 16'b1101, 16'b0001, 4);

    // Zeros only
    step("rst_d", 1'b0, 1'b0, 1'b0);
    run_seq("zeros", 16'b00000000, 16'b00000000, 8);
    check("zeros_state", dut.state_q, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
